// File: rtl/video_mnist_argmax.sv
// Per-pixel argmax over ten MNIST class vote counts. A 4-stage registered
// comparison tree runs alongside a delay line for the pixel sideband.

module video_mnist_argmax_node #(
  parameter int CW = 4,
  parameter int W  = 4 + CW
) (
  input  logic [W-1:0] l,
  input  logic [W-1:0] r,
  output logic [W-1:0] w
);
  // The right side wins only on a strictly larger count, so ties keep the lower class index.
  assign w = (r[CW-1:0] > l[CW-1:0]) ? r : l;
endmodule

module video_mnist_argmax #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 24,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
  input  logic                      s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]    s_axi4s_tdata,
  input  logic                      s_axi4s_tbinary,
  input  logic                      s_axi4s_tvalidation,
  input  logic [10*TCOUNT_WIDTH-1:0] s_axi4s_tcount_all,
  input  logic                      s_axi4s_tvalid,
  output logic                      s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0]  m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]    m_axi4s_tdata,
  output logic                      m_axi4s_tbinary,
  output logic                      m_axi4s_tvalidation,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready
);
  localparam int STAGES = 4;
  localparam int IW     = 4;
  localparam int CAND_W = IW + TCOUNT_WIDTH;

  typedef struct packed {
    logic [IW-1:0]           idx;
    logic [TCOUNT_WIDTH-1:0] cnt;
  } cand_t;

  typedef struct packed {
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   tlast;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tbinary;
    logic                   tvalidation;
  } side_t;

  logic             cke;
  logic [STAGES:1]  vld_pipe;
  side_t            side_pipe [STAGES:1];

  cand_t [9:0] cand_in;
  cand_t [4:0] win0, a_q;
  cand_t [1:0] win1;
  cand_t [2:0] b_q;
  cand_t       win2;
  cand_t [1:0] c_q;
  cand_t       win3, f_q;

  assign cke            = m_axi4s_tready || !m_axi4s_tvalid;
  assign s_axi4s_tready = cke;
  assign m_axi4s_tvalid = vld_pipe[STAGES];

  genvar k;
  for (k = 0; k < 10; k++) begin : g_in
    assign cand_in[k].idx = IW'(k);
    assign cand_in[k].cnt = s_axi4s_tcount_all[k*TCOUNT_WIDTH +: TCOUNT_WIDTH];
  end

  for (k = 0; k < 5; k++) begin : g_st0
    video_mnist_argmax_node #(.CW(TCOUNT_WIDTH), .W(CAND_W)) u_node (
      .l(cand_in[2*k]), .r(cand_in[2*k+1]), .w(win0[k])
    );
  end

  for (k = 0; k < 2; k++) begin : g_st1
    video_mnist_argmax_node #(.CW(TCOUNT_WIDTH), .W(CAND_W)) u_node (
      .l(a_q[2*k]), .r(a_q[2*k+1]), .w(win1[k])
    );
  end

  video_mnist_argmax_node #(.CW(TCOUNT_WIDTH), .W(CAND_W)) u_st2 (
    .l(b_q[0]), .r(b_q[1]), .w(win2)
  );

  video_mnist_argmax_node #(.CW(TCOUNT_WIDTH), .W(CAND_W)) u_st3 (
    .l(c_q[0]), .r(c_q[1]), .w(win3)
  );

  // Only the valid bits are reset; payload is don't-care while invalid.
  always_ff @(posedge aclk) begin
    if (!aresetn)  vld_pipe <= '0;
    else if (cke)  vld_pipe <= {vld_pipe[STAGES-1:1], s_axi4s_tvalid};
  end

  always_ff @(posedge aclk) begin
    if (cke) begin
      side_pipe[1] <= {s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata,
                       s_axi4s_tbinary, s_axi4s_tvalidation};
      for (int i = 2; i <= STAGES; i++) side_pipe[i] <= side_pipe[i-1];
      a_q <= win0;
      b_q <= {a_q[4], win1};
      c_q <= {b_q[2], win2};
      f_q <= win3;
    end
  end

  assign m_axi4s_tnumber     = TNUMBER_WIDTH'(f_q.idx);
  assign m_axi4s_tcount      = f_q.cnt;
  assign m_axi4s_tuser       = side_pipe[STAGES].tuser;
  assign m_axi4s_tlast       = side_pipe[STAGES].tlast;
  assign m_axi4s_tdata       = side_pipe[STAGES].tdata;
  assign m_axi4s_tbinary     = side_pipe[STAGES].tbinary;
  assign m_axi4s_tvalidation = side_pipe[STAGES].tvalidation;
endmodule

// File: tb/tb_video_mnist_argmax.sv
// Self-checking bench for video_mnist_argmax: directed beats plus a
// scoreboard fed at input acceptance and drained at output handshake.

module tb_video_mnist_argmax;
  localparam int TUW = 1, TDW = 24, TNW = 4, TCW = 4;
  localparam int CV  = 10*TCW;
  localparam int EW  = TUW + 1 + TDW + 1 + 1 + TNW + TCW;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [TUW-1:0]  s_axi4s_tuser = '0;
  logic            s_axi4s_tlast = 1'b0;
  logic [TDW-1:0]  s_axi4s_tdata = '0;
  logic            s_axi4s_tbinary = 1'b0;
  logic            s_axi4s_tvalidation = 1'b0;
  logic [CV-1:0]   s_axi4s_tcount_all = '0;
  logic            s_axi4s_tvalid = 1'b0;
  logic            s_axi4s_tready;
  logic [TUW-1:0]  m_axi4s_tuser;
  logic            m_axi4s_tlast;
  logic [TNW-1:0]  m_axi4s_tnumber;
  logic [TCW-1:0]  m_axi4s_tcount;
  logic [TDW-1:0]  m_axi4s_tdata;
  logic            m_axi4s_tbinary;
  logic            m_axi4s_tvalidation;
  logic            m_axi4s_tvalid;
  logic            m_axi4s_tready = 1'b1;

  int checks = 0, failures = 0;
  logic [EW-1:0] sb [$];
  bit bp_mode = 1'b0;
  logic [EW-1:0] act, held, expv;
  bit stalled = 1'b0;

  always #5 aclk = ~aclk;

  video_mnist_argmax #(.TUSER_WIDTH(TUW), .TDATA_WIDTH(TDW),
                       .TNUMBER_WIDTH(TNW), .TCOUNT_WIDTH(TCW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tbinary(s_axi4s_tbinary),
    .s_axi4s_tvalidation(s_axi4s_tvalidation), .s_axi4s_tcount_all(s_axi4s_tcount_all),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tnumber(m_axi4s_tnumber), .m_axi4s_tcount(m_axi4s_tcount),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tbinary(m_axi4s_tbinary),
    .m_axi4s_tvalidation(m_axi4s_tvalidation), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready)
  );

  assign act = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, m_axi4s_tbinary,
                m_axi4s_tvalidation, m_axi4s_tnumber, m_axi4s_tcount};

  // Linear scan: first strictly larger count wins, i.e. lowest index on ties.
  function automatic logic [TNW+TCW-1:0] ref_argmax(input logic [CV-1:0] c);
    logic [TCW-1:0] best;
    int bi;
    best = c[TCW-1:0];
    bi = 0;
    for (int k = 1; k < 10; k++)
      if (c[k*TCW +: TCW] > best) begin best = c[k*TCW +: TCW]; bi = k; end
    return {TNW'(bi), best};
  endfunction

  function automatic logic [CV-1:0] fill(input logic [TCW-1:0] v);
    logic [CV-1:0] c;
    for (int k = 0; k < 10; k++) c[k*TCW +: TCW] = v;
    return c;
  endfunction

  always @(posedge aclk) begin
    #1;
    m_axi4s_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor: handshakes are evaluated mid-cycle, ahead of the edge that completes them.
  always @(negedge aclk) begin
    if (!aresetn) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checks++;
        assert (m_axi4s_tvalid === 1'b1 && act === held) else begin
          failures++;
          $error("FAIL stall_hold observed=%h expected=%h", act, held);
        end
      end
      if (m_axi4s_tvalid === 1'b1 && m_axi4s_tready) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_beat observed=%h expected=none", act);
        end
        if (sb.size() > 0) begin
          expv = sb.pop_front();
          checks++;
          assert (act === expv) else begin
            failures++;
            $error("FAIL beat observed=%h expected=%h", act, expv);
          end
        end
      end
      stalled = (m_axi4s_tvalid === 1'b1) && !m_axi4s_tready;
      held = act;
      if (s_axi4s_tvalid && s_axi4s_tready === 1'b1)
        sb.push_back({s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata, s_axi4s_tbinary,
                      s_axi4s_tvalidation, ref_argmax(s_axi4s_tcount_all)});
    end
  end

  task automatic send(input logic [TUW-1:0] u, input logic l, input logic [TDW-1:0] d,
                      input logic b, input logic v, input logic [CV-1:0] c);
    bit done;
    done = 1'b0;
    s_axi4s_tuser = u; s_axi4s_tlast = l; s_axi4s_tdata = d;
    s_axi4s_tbinary = b; s_axi4s_tvalidation = v; s_axi4s_tcount_all = c;
    s_axi4s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      done = (s_axi4s_tready === 1'b1);
      @(posedge aclk);
    end
    #1;
    s_axi4s_tvalid = 1'b0;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=1", done);
    end
  endtask

  task automatic send_rand();
    logic [CV-1:0] c;
    c[31:0]  = $urandom();
    c[CV-1:32] = (CV-32)'($urandom());
    if ($urandom_range(0, 3) == 0) c = fill(TCW'($urandom_range(0, 15)));
    send(TUW'($urandom()), 1'($urandom()), TDW'($urandom()), 1'($urandom()), 1'($urandom()), c);
  endtask

  // Single beat into an empty pipe: checks latency and the winner against constants.
  task automatic one_beat(input logic [TDW-1:0] d, input logic [CV-1:0] c,
                          input logic [TNW-1:0] en, input logic [TCW-1:0] ec);
    send(1'b1, 1'b0, d, 1'b1, 1'b1, c);
    for (int i = 1; i < 3; i++) begin
      @(posedge aclk); #1;
      checks++;
      assert (m_axi4s_tvalid === 1'b0) else begin
        failures++;
        $error("FAIL early_valid observed=%b expected=0", m_axi4s_tvalid);
      end
    end
    @(posedge aclk); #1;
    checks++;
    assert (m_axi4s_tvalid === 1'b1 && m_axi4s_tnumber === en && m_axi4s_tcount === ec
            && m_axi4s_tdata === d && m_axi4s_tvalidation === 1'b1) else begin
      failures++;
      $error("FAIL one_beat observed=v%b n%0d c%0d d%h expected=v1 n%0d c%0d d%h",
             m_axi4s_tvalid, m_axi4s_tnumber, m_axi4s_tcount, m_axi4s_tdata, en, ec, d);
    end
    @(posedge aclk); #1;
    checks++;
    assert (m_axi4s_tvalid === 1'b0) else begin
      failures++;
      $error("FAIL single_valid observed=%b expected=0", m_axi4s_tvalid);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge aclk);
    repeat (6) @(posedge aclk);
    #1;
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CV-1:0] c;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    assert (m_axi4s_tvalid === 1'b0 && s_axi4s_tready === 1'b1) else begin
      failures++;
      $error("FAIL reset_state observed=v%b r%b expected=v0 r1", m_axi4s_tvalid, s_axi4s_tready);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int k = 0; k < 10; k++) c[k*TCW +: TCW] = TCW'(k);
    one_beat(24'h123456, c, 4'd9, 4'd9);
    one_beat(24'h000001, fill(4'd5), 4'd0, 4'd5);
    c = fill(4'd3);
    c[4*TCW +: TCW] = 4'd12;
    c[7*TCW +: TCW] = 4'd12;
    one_beat(24'h000002, c, 4'd4, 4'd12);
    one_beat(24'h000003, fill(4'd0), 4'd0, 4'd0);
    c = fill(4'd14);
    c[2*TCW +: TCW] = 4'd15;
    one_beat(24'h000004, c, 4'd2, 4'd15);

    for (int i = 0; i < 64; i++) send_rand();
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 500; i++) send_rand();
    drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge aclk); #1;

    for (int i = 0; i < 3; i++) send_rand();
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    checks++;
    assert (m_axi4s_tvalid === 1'b0) else begin
      failures++;
      $error("FAIL reset_flush observed=%b expected=0", m_axi4s_tvalid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      checks++;
      assert (m_axi4s_tvalid === 1'b0) else begin
        failures++;
        $error("FAIL flushed_beat observed=%b expected=0", m_axi4s_tvalid);
      end
    end
    c = fill(4'd1);
    c[6*TCW +: TCW] = 4'd8;
    one_beat(24'hABCDEF, c, 4'd6, 4'd8);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_mnist_argmax.md
# video_mnist_argmax

Upstream neighbour of the MNIST colouring stage.
- Receives, per pixel, the ten per-class vote counts from the MNIST classifier.
- Selects the winning class (argmax) and its count through a 4-stage registered comparison tree.
- Emits the result as `tnumber`/`tcount` alongside the delayed pixel data, binary bit and validation flag, in the form the colouring stage consumes.
- Uses the same single-enable AXI4-Stream pipeline style as its neighbours.

## Interface
Parameters:
- TUSER_WIDTH, 1, width of tuser sideband
- TDATA_WIDTH, 24, width of pixel data
- TNUMBER_WIDTH, 4, width of class index output (must be ≥4; classes 0..9)
- TCOUNT_WIDTH, 4, width of one class count

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock is aclk
- s_axi4s_tuser  in  TUSER_WIDTH  frame-start sideband
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  TDATA_WIDTH  pixel data
- s_axi4s_tbinary  in  1  binarised pixel
- s_axi4s_tvalidation  in  1  classifier "digit present" flag
- s_axi4s_tcount_all  in  10*TCOUNT_WIDTH  class counts; class k at bits [k*TCOUNT_WIDTH +: TCOUNT_WIDTH]
- s_axi4s_tvalid  in  1  input valid
- s_axi4s_tready  out  1  input ready
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser
- m_axi4s_tlast  out  1  delayed tlast
- m_axi4s_tnumber  out  TNUMBER_WIDTH  winning class index 0..9
- m_axi4s_tcount  out  TCOUNT_WIDTH  winning class count
- m_axi4s_tdata  out  TDATA_WIDTH  delayed tdata
- m_axi4s_tbinary  out  1  delayed tbinary
- m_axi4s_tvalidation  out  1  delayed tvalidation
- m_axi4s_tvalid  out  1  output valid
- m_axi4s_tready  in  1  output ready

## Operation
Global pipeline enable:
- `cke = s_axi4s_tready = m_axi4s_tready || !m_axi4s_tvalid`, combinational.
- When cke=1, all stages advance and input is sampled (including when tvalid=0, so bubbles propagate). When cke=0, all stage registers hold.

Comparison tree: each node outputs an (index, count) pair.
- Pair rule: right wins only if its count is strictly greater than left; otherwise left wins. Left always carries the lower class index, so ties resolve to the lowest index.
- st0: pairs (0,1),(2,3),(4,5),(6,7),(8,9) give 5 winners a0..a4.
- st1: (a0,a1),(a2,a3); a4 passes unchanged. Gives b0..b2.
- st2: (b0,b1); b2 passes. Gives c0,c1.
- st3: (c0,c1) gives final index/count, driven directly from st3 registers.

Width and sideband rules:
- Index is zero-extended to TNUMBER_WIDTH.
- Counts are unsigned; compared at TCOUNT_WIDTH with no saturation or extension.
- tuser, tlast, tdata, tbinary, tvalidation and valid are delayed through the same 4 stages in lockstep.
- No combinational path from s_* data to m_* outputs.

## Timing
- Latency: 4 enabled cycles. A beat accepted at edge N appears on m_* after edge N+3, i.e. at edge N+4 with m_axi4s_tready held high.
- Throughput: 1 beat/cycle while m_axi4s_tready=1.
- Backpressure: m_axi4s_tvalid=1 and m_axi4s_tready=0 drops s_axi4s_tready in the same cycle. The whole pipe freezes, m_* stay stable, and no beat is lost or duplicated.
- Empty output: m_axi4s_tvalid=0 holds s_axi4s_tready=1 regardless of m_axi4s_tready, so internal bubbles drain.
- Reset: aresetn=0 at a clock edge clears all stage valid bits, so m_axi4s_tvalid=0 from the next cycle. Data and sideband registers are unspecified after reset and must not be checked while m_axi4s_tvalid=0.
- Reset mid-stream: beats in flight are discarded. Output resumes 4 cycles after the first accepted post-reset beat.
- s_axi4s_tready is 1 during reset, because m_axi4s_tvalid is 0.

## Test plan
- Single beat, counts k→k (class 9=9 largest), tdata=24'h123456, tvalidation=1 -> 4 cycles later tnumber=9, tcount=9, tdata=24'h123456, tvalidation=1, one valid beat.
- Ties: all counts 5 -> tnumber=0, tcount=5. Counts 3 except classes 4 and 7 =12 -> tnumber=4, tcount=12. All zero -> tnumber=0, tcount=0.
- Streaming: 64 random beats with tready=1 -> one output per cycle, each matching a reference argmax (lowest index on ties), order and tuser/tlast preserved.
- Backpressure: random m_axi4s_tready (~50%) over 500 beats -> outputs identical to the streaming reference sequence; m_* stable while tvalid=1 and tready=0.
- Reset mid-stream: assert aresetn=0 for 1 cycle with 3 beats in flight -> m_axi4s_tvalid=0 next cycle; none of the 3 beats appear; a new beat emerges after 4 cycles.
- Max count: class 2 = 2^TCOUNT_WIDTH-1, others = 2^TCOUNT_WIDTH-2 -> tnumber=2, tcount=all ones.
